// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port synchronous framebuffer RAM between the display
// scan-out and a CPU write channel. The display always wins. CPU writes wait
// in a small FIFO and are drained into idle RAM cycles. If vblank_only is
// set, they are drained only during vertical blanking.
//
// Ports
//   clk, reset_n              pixel clock; asynchronous active-low reset
//   hdata_in, vdata_in        current pixel column / line from timing gen
//   de_in, hsync_in, vsync_in timing-generator data enable and syncs
//   vblank_only               1 = drain CPU writes only in vertical blanking
//   cpu_wr_valid/ready        CPU write handshake; cpu_addr, cpu_wdata payload
//   mem_addr, mem_rd, mem_wr  RAM control (read latency 1)
//   mem_wdata, mem_rdata      RAM write / read data
//   pix_rgb                   RGB565 pixel, aligned with de_o/hsync_o/vsync_o
//   de_o, hsync_o, vsync_o    timing inputs delayed by two clocks
//   frame_irq                 one-cycle pulse on entry to vertical blanking
//   region_state              debug: current region FSM state
//   fill_level                debug: CPU write FIFO occupancy
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int WIDTH  = 12,
  parameter int HSIZE  = 800,
  parameter int VSIZE  = 600,
  parameter int AW     = 19,
  parameter int FDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         hdata_in,
  input  logic [WIDTH-1:0]         vdata_in,
  input  logic                     de_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     vblank_only,
  input  logic                     cpu_wr_valid,
  output logic                     cpu_wr_ready,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [15:0]              cpu_wdata,
  output logic [AW-1:0]            mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  output logic [15:0]              pix_rgb,
  output logic                     de_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     frame_irq,
  output logic [1:0]               region_state,
  output logic [$clog2(FDEPTH):0]  fill_level
);

  localparam int PW = $clog2(FDEPTH);

  localparam logic [WIDTH-1:0] HSIZE_W  = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] VSIZE_W  = WIDTH'(VSIZE);
  localparam logic [PW:0]      CNT_FULL = (PW+1)'(FDEPTH);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_HBLANK = 2'd1;
  localparam logic [1:0] ST_VBLANK = 2'd2;

  // ---------------------------------------------------------------------------
  // Region FSM: a registered copy of where the timing generator currently is.
  // Because it is registered, the drain decision sees the region of the
  // previous cycle. Reset puts it in VBLANK. As a result, an entry into
  // VBLANK straight after reset produces no frame_irq.
  // ---------------------------------------------------------------------------
  logic [1:0] state;
  logic [1:0] state_next;
  logic       in_vblank;

  assign in_vblank = (vdata_in >= VSIZE_W);

  always_comb begin
    state_next = ST_ACTIVE;
    if (in_vblank) begin
      state_next = ST_VBLANK;
    end else if (hdata_in >= HSIZE_W) begin
      state_next = ST_HBLANK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_VBLANK;
      frame_irq <= 1'b0;
    end else begin
      state     <= state_next;
      frame_irq <= (state_next == ST_VBLANK) && (state != ST_VBLANK);
    end
  end

  assign region_state = state;

  // ---------------------------------------------------------------------------
  // CPU write FIFO.
  // Handshake: a write transfers on every clock edge where cpu_wr_valid and
  // cpu_wr_ready are both 1. Once the CPU raises cpu_wr_valid, it must keep
  // valid, cpu_addr and cpu_wdata stable until the transfer happens.
  // cpu_wr_ready depends only on FIFO state, never on cpu_wr_valid. It stays
  // low during reset and for the rest of that cycle. It goes high at the
  // first clock edge after reset is released.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] fifo_addr [FDEPTH];
  logic [15:0]   fifo_data [FDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          ready_en;
  logic          push;
  logic          pop;
  logic          drain;

  assign cpu_wr_ready = ready_en && (count != CNT_FULL);
  assign push         = cpu_wr_valid && cpu_wr_ready;

  // A CPU write may use the RAM only when the display does not need it.
  assign drain = (count != '0) && !de_in &&
                 (!vblank_only || (state == ST_VBLANK));
  assign pop   = drain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset. Reset empties the FIFO through the pointers and
  // the count, so stale entries can never be popped.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  assign fill_level = count;

  // ---------------------------------------------------------------------------
  // Display address counter. It is cleared on any cycle inside vertical
  // blanking, so every frame starts at address 0 whatever happened before.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] pix_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_addr <= '0;
    end else if (in_vblank) begin
      pix_addr <= '0;
    end else if (de_in) begin
      pix_addr <= pix_addr + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port. mem_rd follows de_in combinationally, including during reset.
  // mem_wr is only possible when de_in=0, so the two never overlap.
  // ---------------------------------------------------------------------------
  assign mem_rd    = de_in;
  assign mem_wr    = drain;
  assign mem_addr  = de_in ? pix_addr : fifo_addr[rd_ptr];
  assign mem_wdata = fifo_data[rd_ptr];

  // ---------------------------------------------------------------------------
  // Output pipeline. Stage 1 lines the timing up with the RAM read latency.
  // Stage 2 registers the read word so that it lines up with de_o. The
  // delayed data enable gates the pixel, so blanked pixels are always black
  // whatever stale word the RAM is still presenting.
  // ---------------------------------------------------------------------------
  logic de_d1;
  logic hs_d1;
  logic vs_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_d1   <= 1'b0;
      hs_d1   <= 1'b0;
      vs_d1   <= 1'b0;
      de_o    <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      pix_rgb <= 16'h0000;
    end else begin
      de_d1   <= de_in;
      hs_d1   <= hsync_in;
      vs_d1   <= vsync_in;
      de_o    <= de_d1;
      hsync_o <= hs_d1;
      vsync_o <= vs_d1;
      pix_rgb <= de_d1 ? mem_rdata : 16'h0000;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

  // Scaled-down raster so that several frames fit in a short run
  localparam int WIDTH  = 12;
  localparam int HS     = 20;
  localparam int VS     = 10;
  localparam int HT     = 28;
  localparam int VT     = 13;
  localparam int HSS    = 22;
  localparam int HSE    = 24;
  localparam int VSS    = 11;
  localparam int VSE    = 12;
  localparam int AW     = 12;
  localparam int FDEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] hdata_in, vdata_in;
  logic de_in, hsync_in, vsync_in, vblank_only;
  logic cpu_wr_valid, cpu_wr_ready;
  logic [AW-1:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [AW-1:0] mem_addr;
  logic mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] pix_rgb;
  logic de_o, hsync_o, vsync_o, frame_irq;
  logic [1:0] region_state;
  logic [2:0] fill_level;

  vga_fb_arbiter #(
    .WIDTH(WIDTH), .HSIZE(HS), .VSIZE(VS), .AW(AW), .FDEPTH(FDEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .hdata_in(hdata_in), .vdata_in(vdata_in),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vblank_only(vblank_only),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_rgb(pix_rgb), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .frame_irq(frame_irq), .region_state(region_state), .fill_level(fill_level)
  );

  // ---------------- RAM model: word = address, read latency 1 ----------------
  logic [15:0] ram [0:(1<<AW)-1];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= 16'(i);
      ram_init <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int conflicts = 0;
  int wr_count = 0;
  logic [18:0] exp_q[$];

  always begin
    @(negedge clk);
    #2;
    if (mem_rd && mem_wr) conflicts++;
    if (mem_wr) wr_count++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  int vbo_n = 0;
  int val_n = 0;
  int addr_n = 0;
  int data_n = 0;

  task automatic tick(input int hh, input int vv);
    @(negedge clk);
    hdata_in     = WIDTH'(hh);
    vdata_in     = WIDTH'(vv);
    de_in        = (hh < HS) && (vv < VS);
    hsync_in     = (hh >= HSS) && (hh < HSE);
    vsync_in     = (vv >= VSS) && (vv < VSE);
    vblank_only  = (vbo_n != 0);
    cpu_wr_valid = (val_n != 0);
    cpu_addr     = AW'(addr_n);
    cpu_wdata    = 16'(data_n);
    #1;
  endtask

  function automatic logic [18:0] pix_exp(input int hh, input int vv);
    logic de, hs, vs;
    de = (hh < HS) && (vv < VS);
    hs = (hh >= HSS) && (hh < HSE);
    vs = (vv >= VSS) && (vv < VSE);
    return {de, hs, vs, de ? 16'(vv * HS + hh) : 16'h0000};
  endfunction

  task automatic sb_step(input int hh, input int vv);
    logic [18:0] e;
    exp_q.push_back(pix_exp(hh, vv));
    if (exp_q.size() > 2) begin
      e = exp_q.pop_front();
      chk("pix_out", 32'({de_o, hsync_o, vsync_o, pix_rgb}), 32'(e));
    end
  endtask

  task automatic run_frame(input int vbo, input int hbw);
    int irqs;
    int de;
    int ew;
    irqs = 0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        vbo_n = vbo;
        val_n = 0;
        if (hbw != 0 && v == 2 && h == HS - 5) begin
          val_n = 1; addr_n = 'h300; data_n = 'hC000;
        end
        if (hbw != 0 && v == 2 && h == HS - 4) begin
          val_n = 1; addr_n = 'h301; data_n = 'hC001;
        end
        tick(h, v);
        de = ((h < HS) && (v < VS)) ? 1 : 0;
        ew = (hbw != 0 && v == 2 && (h == HS || h == HS + 1)) ? 1 : 0;
        if (val_n != 0) chk("hb_ready", 32'(cpu_wr_ready), 32'd1);
        chk("mem_rd", 32'(mem_rd), 32'(de));
        if (de != 0) chk("rd_addr", 32'(mem_addr), 32'(v * HS + h));
        chk("mem_wr", 32'(mem_wr), 32'(ew));
        if (ew != 0) begin
          chk("hb_wr_addr", 32'(mem_addr), (h == HS) ? 32'h300 : 32'h301);
          chk("hb_wr_data", 32'(mem_wdata), (h == HS) ? 32'hC000 : 32'hC001);
        end
        chk("frame_irq", 32'(frame_irq), (v == VS && h == 1) ? 32'd1 : 32'd0);
        irqs += 32'(frame_irq);
        sb_step(h, v);
      end
    end
    chk("irq_per_frame", 32'(irqs), 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int h; int v; int de; int vbo; int val; int addr; int data;
    int e_rd; int e_wr; int e_maddr; int e_wdata; int e_ready; int e_irq; int e_fill; int e_state;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int base;
    //        h  v de vbo val addr   data     rd wr maddr  wdata  rdy irq fill st
    tbl[0]  = '{0, 0, 1, 1, 1, 'h100, 'hA001, 1, 0, 0,     0,      1, 0, 0, 2};
    tbl[1]  = '{1, 0, 1, 1, 1, 'h101, 'hA002, 1, 0, 1,     0,      1, 0, 1, 0};
    tbl[2]  = '{2, 0, 1, 1, 1, 'h102, 'hA003, 1, 0, 2,     0,      1, 0, 2, 0};
    tbl[3]  = '{3, 0, 1, 1, 1, 'h103, 'hA004, 1, 0, 3,     0,      1, 0, 3, 0};
    tbl[4]  = '{4, 0, 1, 1, 1, 'h104, 'hA005, 1, 0, 4,     0,      0, 0, 4, 0};
    tbl[5]  = '{20, 0, 0, 1, 1, 'h104, 'hA005, 0, 0, 0,    0,      0, 0, 4, 0};
    tbl[6]  = '{21, 0, 0, 1, 1, 'h104, 'hA005, 0, 0, 0,    0,      0, 0, 4, 1};
    tbl[7]  = '{0, 10, 0, 1, 1, 'h104, 'hA005, 0, 0, 0,    0,      0, 0, 4, 1};
    tbl[8]  = '{1, 10, 0, 1, 1, 'h104, 'hA005, 0, 1, 'h100, 'hA001, 0, 1, 4, 2};
    tbl[9]  = '{2, 10, 0, 1, 1, 'h104, 'hA005, 0, 1, 'h101, 'hA002, 1, 0, 3, 2};
    tbl[10] = '{3, 10, 0, 1, 0, 0, 0,          0, 1, 'h102, 'hA003, 1, 0, 3, 2};
    tbl[11] = '{4, 10, 0, 1, 0, 0, 0,          0, 1, 'h103, 'hA004, 1, 0, 2, 2};
    tbl[12] = '{5, 10, 0, 1, 0, 0, 0,          0, 1, 'h104, 'hA005, 1, 0, 1, 2};
    tbl[13] = '{6, 10, 0, 1, 0, 0, 0,          0, 0, 0,     0,      1, 0, 0, 2};
    tbl[14] = '{0, 0, 1, 0, 1, 'h200, 'hB001,  1, 0, 0,     0,      1, 0, 0, 2};
    tbl[15] = '{1, 0, 1, 0, 0, 0, 0,           1, 0, 1,     0,      1, 0, 1, 0};
    tbl[16] = '{2, 0, 0, 0, 0, 0, 0,           0, 1, 'h200, 'hB001, 1, 0, 1, 0};
    tbl[17] = '{3, 0, 0, 1, 1, 'h201, 'hB002,  0, 0, 0,     0,      1, 0, 0, 0};
    tbl[18] = '{4, 0, 0, 1, 0, 0, 0,           0, 0, 0,     0,      1, 0, 1, 0};
    tbl[19] = '{4, 0, 0, 0, 0, 0, 0,           0, 1, 'h201, 'hB002, 1, 0, 1, 0};
    tbl[20] = '{5, 0, 1, 0, 0, 0, 0,           1, 0, 2,     0,      1, 0, 0, 0};

    // ---- reset state ----
    reset_n = 1'b0;
    hdata_in = '0; vdata_in = WIDTH'(VS);
    de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; vblank_only = 1'b1;
    cpu_wr_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    de_in = 1'b1;
    #1;
    chk("rst_mem_rd_hi", 32'(mem_rd), 32'd1);
    de_in = 1'b0;
    #1;
    chk("rst_mem_rd_lo", 32'(mem_rd), 32'd0);
    chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("rst_de_o", 32'(de_o), 32'd0);
    chk("rst_hsync_o", 32'(hsync_o), 32'd0);
    chk("rst_vsync_o", 32'(vsync_o), 32'd0);
    chk("rst_irq", 32'(frame_irq), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_ready", 32'(cpu_wr_ready), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_state", 32'(region_state), 32'd2);
    reset_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(cpu_wr_ready), 32'd0);
    vbo_n = 1; val_n = 0;
    tick(1, VS);
    chk("rel_ready_after_edge", 32'(cpu_wr_ready), 32'd1);
    chk("rel_no_irq", 32'(frame_irq), 32'd0);

    // ---- table-driven vectors: saturation, drain order, push/pop, priority ----
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      hdata_in     = WIDTH'(tbl[i].h);
      vdata_in     = WIDTH'(tbl[i].v);
      de_in        = (tbl[i].de != 0);
      hsync_in     = (tbl[i].h >= HSS) && (tbl[i].h < HSE);
      vsync_in     = (tbl[i].v >= VSS) && (tbl[i].v < VSE);
      vblank_only  = (tbl[i].vbo != 0);
      cpu_wr_valid = (tbl[i].val != 0);
      cpu_addr     = AW'(tbl[i].addr);
      cpu_wdata    = 16'(tbl[i].data);
      #1;
      chk($sformatf("vec%0d_rd", i), 32'(mem_rd), 32'(tbl[i].e_rd));
      chk($sformatf("vec%0d_wr", i), 32'(mem_wr), 32'(tbl[i].e_wr));
      if (tbl[i].e_rd != 0 || tbl[i].e_wr != 0)
        chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_maddr));
      if (tbl[i].e_wr != 0)
        chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wdata));
      chk($sformatf("vec%0d_ready", i), 32'(cpu_wr_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_irq", i), 32'(frame_irq), 32'(tbl[i].e_irq));
      chk($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(tbl[i].e_fill));
      chk($sformatf("vec%0d_state", i), 32'(region_state), 32'(tbl[i].e_state));
    end

    // ---- two frames: fill/pixel pipeline, IRQ, HBLANK drain in frame 2 ----
    exp_q.delete();
    vbo_n = 1; val_n = 0;
    tick(0, VT - 1);
    sb_step(0, VT - 1);
    tick(1, VT - 1);
    chk("irq_prelude", 32'(frame_irq), 32'd1);
    sb_step(1, VT - 1);
    run_frame(1, 0);
    run_frame(0, 1);

    // ---- reset mid-operation with three queued writes ----
    vbo_n = 1;
    for (int h = 0; h < 6; h++) begin
      val_n = (h >= 2 && h <= 4) ? 1 : 0;
      addr_n = 'h400 + h;
      data_n = 'hD000 + h;
      tick(h, 3);
    end
    chk("pre_rst_fill", 32'(fill_level), 32'd3);
    chk("pre_rst_de_o", 32'(de_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("mid_rst_de_o", 32'(de_o), 32'd0);
    chk("mid_rst_hsync_o", 32'(hsync_o), 32'd0);
    chk("mid_rst_vsync_o", 32'(vsync_o), 32'd0);
    chk("mid_rst_irq", 32'(frame_irq), 32'd0);
    chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("mid_rst_ready", 32'(cpu_wr_ready), 32'd0);
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    chk("mid_rst_mem_rd", 32'(mem_rd), 32'd1);
    val_n = 1;
    for (int h = 6; h < 9; h++) begin
      tick(h, 3);
      chk("rst_hold_ready", 32'(cpu_wr_ready), 32'd0);
      chk("rst_hold_wr", 32'(mem_wr), 32'd0);
    end
    reset_n = 1'b1;
    base = wr_count;
    val_n = 0;
    for (int v = 3; v < VT; v++) begin
      for (int h = (v == 3) ? 9 : 0; h < HT; h++) begin
        tick(h, v);
        if (v == 3 && h == 9) chk("post_rst_ready", 32'(cpu_wr_ready), 32'd1);
        chk("post_rst_no_wr", 32'(mem_wr), 32'd0);
      end
    end
    exp_q.delete();
    run_frame(1, 0);
    chk("post_rst_wr_count", 32'(wr_count - base), 32'd0);

    chk("rd_wr_overlap", 32'(conflicts), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
